// File: rtl/led_scan_pkg.sv
// Shared types and row-timing helpers for the LED matrix scan reader.
package led_scan_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      CAPTURE,
      SHIFT,
      LATCH,
      DWELL
   } state_t;

   // Fixed single-cycle FETCH, CAPTURE and LATCH states around each row.
   localparam int unsigned ROW_OVERHEAD = 3;

   function automatic int unsigned row_period(input int unsigned sclk_half,
                                              input int unsigned data_width,
                                              input int unsigned dwell_cycles);
      return ROW_OVERHEAD + 2 * sclk_half * data_width + dwell_cycles;
   endfunction

endpackage

// File: rtl/led_shift_out.sv
// Serialises one row word MSB first onto sdo/sclk; a load pulse captures and starts,
// and done_c flags the final cycle of the last bit's high phase.
module led_shift_out #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned SCLK_HALF  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] data,
   output logic                  sdo,
   output logic                  sclk,
   output logic                  done_c
);
   localparam int unsigned DIV_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
   localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   logic [DATA_WIDTH-1:0] shreg;
   logic [DIV_W-1:0]      div;
   logic [BIT_W-1:0]      bit_cnt;
   logic                  active;
   logic                  half_end;

   assign half_end = (div == DIV_W'(SCLK_HALF - 1));
   assign done_c   = active && sclk && half_end && (bit_cnt == BIT_W'(DATA_WIDTH - 1));
   assign sdo      = shreg[DATA_WIDTH-1];

   // Data advances on the falling sclk transition so sdo is stable for a whole period.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg   <= '0;
         div     <= '0;
         bit_cnt <= '0;
         active  <= 1'b0;
         sclk    <= 1'b0;
      end else if (load) begin
         shreg   <= data;
         div     <= '0;
         bit_cnt <= '0;
         active  <= 1'b1;
         sclk    <= 1'b0;
      end else if (active) begin
         if (!half_end) begin
            div <= div + DIV_W'(1);
         end else begin
            div  <= '0;
            sclk <= !sclk;
            if (sclk) begin
               if (done_c) begin
                  active <= 1'b0;
               end else begin
                  bit_cnt <= bit_cnt + BIT_W'(1);
                  shreg   <= shreg << 1;
               end
            end
         end
      end
   end

endmodule

// File: rtl/led_scan_reader.sv
// Row-by-row LED matrix scanner: fetch a row word, shift it out, latch, then dwell lit.
// Define LED_SCAN_BLANK_EN to blank the display (o_oe_n=1) outside the dwell phase.
module led_scan_reader
   import led_scan_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned ADDR_WIDTH   = 6,
   parameter int unsigned SCLK_HALF    = 2,
   parameter int unsigned DWELL_CYCLES = 256
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_enable,
   output logic                  o_mem_en,
   output logic                  o_mem_wr_en,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   input  logic [DATA_WIDTH-1:0] i_mem_data,
   output logic                  o_sdo,
   output logic                  o_sclk,
   output logic                  o_latch,
   output logic                  o_oe_n,
   output logic [ADDR_WIDTH-1:0] o_row,
   output logic                  o_frame_done,
   output logic                  o_busy
);
   localparam int unsigned DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

   state_t                state;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DWELL_W-1:0]    dwell_cnt;
   logic                  load_c;
   logic                  shift_done_c;
   logic                  last_row_c;
   logic                  dwell_last_c;

   assign load_c       = (state == CAPTURE);
   assign last_row_c   = &addr;
   assign dwell_last_c = (dwell_cnt == DWELL_W'(DWELL_CYCLES - 1));
   assign o_mem_wr_en  = 1'b0;
   assign o_mem_addr   = addr;

   led_shift_out #(
      .DATA_WIDTH (DATA_WIDTH),
      .SCLK_HALF  (SCLK_HALF)
   ) u_shift (
      .clk    (i_clk),
      .rst    (i_rst),
      .load   (load_c),
      .data   (i_mem_data),
      .sdo    (o_sdo),
      .sclk   (o_sclk),
      .done_c (shift_done_c)
   );

   // Outputs are set on the edge entering the state they belong to.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state        <= IDLE;
         addr         <= '0;
         dwell_cnt    <= '0;
         o_row        <= '0;
         o_latch      <= 1'b0;
         o_mem_en     <= 1'b0;
         o_frame_done <= 1'b0;
         o_busy       <= 1'b0;
         o_oe_n       <= 1'b1;
      end else begin
         o_latch      <= 1'b0;
         o_frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (i_enable) begin
                  state    <= FETCH;
                  o_mem_en <= 1'b1;
                  o_busy   <= 1'b1;
               end
            end
            FETCH: begin
               state    <= CAPTURE;
               o_mem_en <= 1'b0;
            end
            CAPTURE: state <= SHIFT;
            SHIFT: begin
               if (shift_done_c) begin
                  state   <= LATCH;
                  o_latch <= 1'b1;
                  o_row   <= addr;
               end
            end
            LATCH: begin
               state        <= DWELL;
               dwell_cnt    <= '0;
               o_oe_n       <= 1'b0;
               o_frame_done <= last_row_c && (DWELL_CYCLES == 1);
            end
            DWELL: begin
               if (dwell_last_c) begin
                  if (i_enable) begin
                     state    <= FETCH;
                     addr     <= addr + ADDR_WIDTH'(1);
                     o_mem_en <= 1'b1;
`ifdef LED_SCAN_BLANK_EN
                     o_oe_n   <= 1'b1;
`else
                     o_oe_n   <= 1'b0;
`endif
                  end else begin
                     state  <= IDLE;
                     addr   <= '0;
                     o_busy <= 1'b0;
                     o_oe_n <= 1'b1;
                  end
               end else begin
                  dwell_cnt    <= dwell_cnt + DWELL_W'(1);
                  o_frame_done <= last_row_c && (dwell_cnt == DWELL_W'(DWELL_CYCLES - 2));
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_led_scan_reader.sv
// Directed bench for led_scan_reader (4-row frame, 32-bit rows, short dwell).
`timescale 1ns/1ps
module tb_led_scan_reader;
   localparam int unsigned DW     = 32;
   localparam int unsigned AW     = 2;
   localparam int unsigned PERIOD = 135;  // 2 + 2*2*32 + 1 + 4
`ifdef LED_SCAN_BLANK_EN
   localparam logic BLANK = 1'b1;
`else
   localparam logic BLANK = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic          mem_en, mem_wr_en, sdo, sclk, latch, oe_n, frame_done, busy;
   logic [AW-1:0] mem_addr, row;
   logic [DW-1:0] mem_data;
   logic [DW-1:0] mem [4];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always #5 clk = ~clk;

   led_scan_reader #(
      .DATA_WIDTH   (DW),
      .ADDR_WIDTH   (AW),
      .SCLK_HALF    (2),
      .DWELL_CYCLES (4)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_enable     (enable),
      .o_mem_en     (mem_en),
      .o_mem_wr_en  (mem_wr_en),
      .o_mem_addr   (mem_addr),
      .i_mem_data   (mem_data),
      .o_sdo        (sdo),
      .o_sclk       (sclk),
      .o_latch      (latch),
      .o_oe_n       (oe_n),
      .o_row        (row),
      .o_frame_done (frame_done),
      .o_busy       (busy)
   );

   // Registered-read frame RAM, one cycle latency
   always @(posedge clk) if (mem_en) mem_data <= mem[mem_addr];

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   // Event recorder
   logic          prev_sclk = 1'b0;
   logic [DW-1:0] cap_word  = '0;
   int            cap_bits  = 0;
   int            en_cnt    = 0;
   int            fetch_addr_q[$];
   int            fetch_cyc_q[$];
   int            latch_row_q[$];
   int            latch_bits_q[$];
   logic [DW-1:0] latch_word_q[$];
   int            done_cyc_q[$];
   logic          oe_shift_q[$];

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         prev_sclk = 1'b0;
         en_cnt    = 0;
         cap_bits  = 0;
      end else begin
         check("mem_wr_en", mem_wr_en, 1'b0);
         if (mem_en) begin
            fetch_addr_q.push_back(int'(mem_addr));
            fetch_cyc_q.push_back(cyc);
            en_cnt++;
            cap_bits = 0;
            cap_word = '0;
         end
         if (sclk && !prev_sclk) begin
            if (cap_bits == 0) oe_shift_q.push_back(oe_n);
            cap_word = {cap_word[DW-2:0], sdo};
            cap_bits++;
         end
         if (latch) begin
            check("latch_sclk_low", sclk, 1'b0);
            check("mem_en_per_row", en_cnt, 1);
            en_cnt = 0;
            latch_row_q.push_back(int'(row));
            latch_word_q.push_back(cap_word);
            latch_bits_q.push_back(cap_bits);
         end
         if (frame_done) done_cyc_q.push_back(cyc);
         prev_sclk = sclk;
      end
   end

   task automatic wait_fetches(input int n, input int limit);
      int k = 0;
      while (fetch_addr_q.size() < n && k < limit) begin
         @(posedge clk);
         k++;
      end
      check($sformatf("fetch_count_%0d", n), fetch_addr_q.size(), n);
   endtask

   task automatic check_latch(input int i, input int exp_row);
      if (latch_row_q.size() > i) begin
         check($sformatf("latch_row_%0d", i), latch_row_q[i], exp_row);
         check($sformatf("latch_word_%0d", i), latch_word_q[i], mem[exp_row]);
         check($sformatf("latch_bits_%0d", i), latch_bits_q[i], DW);
      end else begin
         check($sformatf("latch_missing_%0d", i), latch_row_q.size(), i + 1);
      end
   endtask

   initial begin
      int k;
      int idle_cyc;
      rst    = 1'b1;
      enable = 1'b0;
      mem[0] = 32'h8000_0001;
      mem[1] = 32'hA5A5_0F0F;
      mem[2] = 32'h0000_0000;
      mem[3] = 32'hFFFF_FFFE;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_oe_n", oe_n, 1'b1);
      check("rst_sclk", sclk, 1'b0);
      check("rst_sdo", sdo, 1'b0);
      check("rst_latch", latch, 1'b0);
      check("rst_mem_en", mem_en, 1'b0);
      check("rst_frame_done", frame_done, 1'b0);
      check("rst_row", row, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_wr_en", mem_wr_en, 1'b0);

      // Stays idle while disabled
      @(posedge clk); #1 rst = 1'b0;
      repeat (5) @(negedge clk);
      check("idle_busy", busy, 1'b0);
      check("idle_no_fetch", fetch_addr_q.size(), 0);

      // Full frame plus wrap to row 0
      @(posedge clk); #1 enable = 1'b1;
      wait_fetches(5, 800);
      check("run_busy", busy, 1'b1);
      if (fetch_addr_q.size() >= 5) begin
         for (int i = 0; i < 5; i++)
            check($sformatf("fetch_addr_%0d", i), fetch_addr_q[i], i % 4);
         for (int i = 0; i < 4; i++)
            check($sformatf("row_period_%0d", i), fetch_cyc_q[i+1] - fetch_cyc_q[i], PERIOD);
         check("frame_done_count", done_cyc_q.size(), 1);
         if (done_cyc_q.size() > 0)
            check("frame_done_cycle", done_cyc_q[0], fetch_cyc_q[4] - 1);
      end
      check("latch_count", latch_row_q.size(), 4);
      for (int i = 0; i < 4; i++) check_latch(i, i);
      check("oe_shift_count", oe_shift_q.size(), 4);
      if (oe_shift_q.size() >= 4)
         for (int i = 0; i < 4; i++)
            check($sformatf("oe_n_shift_%0d", i), oe_shift_q[i], BLANK ? 1'b1 : (i == 0));

      // Reset in the middle of shifting row 0 of the second frame
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!sclk && k < 300);
      check("wait_sclk_high", sclk, 1'b1);
      check("oe_n_pre_reset", oe_n, BLANK);
      #1 rst = 1'b1;
      #1;
      check("mid_rst_oe_n", oe_n, 1'b1);
      check("mid_rst_sclk", sclk, 1'b0);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_addr", mem_addr, 0);
      repeat (4) @(negedge clk);
      check("no_latch_abandoned", latch_row_q.size(), 4);
      fetch_addr_q.delete();
      fetch_cyc_q.delete();
      latch_row_q.delete();
      latch_bits_q.delete();
      latch_word_q.delete();
      done_cyc_q.delete();
      oe_shift_q.delete();
      @(posedge clk); #1 rst = 1'b0;

      // Restart at row 0, then drop enable while row 1 shifts
      wait_fetches(2, 300);
      if (fetch_addr_q.size() >= 2) begin
         check("restart_addr_0", fetch_addr_q[0], 0);
         check("restart_addr_1", fetch_addr_q[1], 1);
      end
      k = 0;
      while (cap_bits < 3 && k < 100) begin
         @(posedge clk);
         k++;
      end
      check("row1_shifting", cap_bits >= 3, 1'b1);
      #1 enable = 1'b0;
      k = 0;
      do begin
         @(negedge clk);
         #1;
         k++;
      end while (busy && k < 300);
      idle_cyc = cyc;
      check("stop_busy", busy, 1'b0);
      if (fetch_cyc_q.size() >= 2)
         check("stop_cycle", idle_cyc, fetch_cyc_q[1] + PERIOD);
      check("stop_latch_count", latch_row_q.size(), 2);
      check_latch(0, 0);
      check_latch(1, 1);
      if (oe_shift_q.size() >= 2) begin
         check("oe_n_restart_0", oe_shift_q[0], 1'b1);
         check("oe_n_restart_1", oe_shift_q[1], BLANK);
      end
      check("stop_addr", mem_addr, 0);
      check("stop_oe_n", oe_n, 1'b1);
      repeat (10) @(negedge clk);
      check("stop_no_fetch", fetch_addr_q.size(), 2);

      // Re-enable from idle resumes at row 0
      @(posedge clk); #1 enable = 1'b1;
      wait_fetches(3, 10);
      if (fetch_addr_q.size() >= 3) check("resume_addr", fetch_addr_q[2], 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/led_scan_reader.md
LED_SCAN_READER -- requirements
Module: led_scan_reader

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving pixels per row (one memory word per row).
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 6, giving frame depth of 2^ADDR_WIDTH rows.
REQ-003 The block SHALL have parameter SCLK_HALF, default 2, giving i_clk cycles per o_sclk half-period (>=1).
REQ-004 The block SHALL have parameter DWELL_CYCLES, default 256, giving display-on cycles per row (>=1).
REQ-005 The block SHALL have port i_clk, input, 1 bit: the single clock, with all logic on its rising edge.
REQ-006 The block SHALL have port i_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The block SHALL have port i_enable, input, 1 bit: scan run request.
REQ-008 The block SHALL have port o_mem_en, output, 1 bit: frame RAM enable.
REQ-009 The block SHALL have port o_mem_wr_en, output, 1 bit: RAM write enable, constant 0.
REQ-010 The block SHALL have port o_mem_addr, output, ADDR_WIDTH bits: row address to RAM.
REQ-011 The block SHALL have port i_mem_data, input, DATA_WIDTH bits: RAM read data, registered in the RAM with 1-cycle latency.
REQ-012 The block SHALL have ports o_sdo, o_sclk and o_latch, output, 1 bit each: serial pixel data, shift clock and latch pulse to the column drivers.
REQ-013 The block SHALL have ports o_oe_n (output, 1 bit, active-low display enable) and o_row (output, ADDR_WIDTH bits, active row select).
REQ-014 The block SHALL have ports o_frame_done (output, 1 bit, one-cycle end-of-frame pulse) and o_busy (output, 1 bit, state != IDLE).

Function
REQ-015 The FSM SHALL use states IDLE, FETCH, CAPTURE, SHIFT, LATCH and DWELL.
REQ-016 In IDLE with i_enable=1, the FSM SHALL go to FETCH on the next edge; otherwise it SHALL stay in IDLE.
REQ-017 FETCH SHALL last 1 cycle, with o_mem_en=1 and o_mem_addr=current row, then go to CAPTURE.
REQ-018 CAPTURE SHALL last 1 cycle, with o_mem_en=0, load i_mem_data into the shift register, then go to SHIFT.
REQ-019 SHIFT SHALL output the bits MSB first: o_sdo stable for a full o_sclk period, o_sclk low for SCLK_HALF cycles then high for SCLK_HALF cycles per bit, and exactly DATA_WIDTH rising o_sclk edges per row.
REQ-020 After the last bit's high phase, SHIFT SHALL go to LATCH with o_sclk=0.
REQ-021 LATCH SHALL assert o_latch for exactly 1 cycle and load o_row with the shifted address at that edge.
REQ-022 DWELL SHALL hold o_oe_n=0 for DWELL_CYCLES cycles.
REQ-023 At the end of DWELL the address SHALL increment mod 2^ADDR_WIDTH, wrapping from 2^ADDR_WIDTH-1 to 0.
REQ-024 o_frame_done SHALL pulse for 1 cycle on the final DWELL cycle of row 2^ADDR_WIDTH-1.
REQ-025 At the end of DWELL the FSM SHALL go to FETCH if i_enable=1, else to IDLE with the address reset to 0.
REQ-026 i_enable deassertion mid-row SHALL take effect only at a row boundary.
REQ-027 Row period SHALL equal 2 + 2*SCLK_HALF*DATA_WIDTH + 1 + DWELL_CYCLES cycles.
REQ-028 o_mem_wr_en SHALL always be 0.
REQ-029 o_mem_en SHALL be high only in FETCH.

Reset
REQ-030 While i_rst=1, the block SHALL asynchronously force state IDLE, address 0, o_row 0, shift register 0, o_sdo/o_sclk/o_latch/o_mem_en/o_frame_done/o_busy 0 and o_oe_n 1.
REQ-031 Reset mid-row SHALL abandon the row with no latch pulse; scanning SHALL restart from row 0.

Configuration
REQ-032 With LED_SCAN_BLANK_EN defined, o_oe_n SHALL be 1 in every state except DWELL (blank during fetch, shift and latch).
REQ-033 Without LED_SCAN_BLANK_EN, after the first LATCH o_oe_n SHALL stay 0 until IDLE or reset, so the previous row remains lit during shifting.

Structure
REQ-034 Package led_scan_pkg SHALL hold the state enumeration typedef and the localparam row-period formula.
REQ-035 Serialisation (shift register, SCLK_HALF divider, bit counter) SHALL be the sub-module led_shift_out, with load/start/done handshake to the FSM.

Verification
REQ-036 With the RAM model holding word0=32'h8000_0001 and i_enable=1, the bench SHALL see o_sdo sample 1,0x30,1 on the o_sclk rises, then an o_latch pulse with o_row=0.
REQ-037 With ADDR_WIDTH=2 and DWELL_CYCLES=4, the bench SHALL see addresses 0,1,2,3,0 fetched, o_frame_done pulsed once after row 3, and period 2+128+1+4=135 cycles.
REQ-038 Dropping i_enable during SHIFT of row 1 SHALL complete row 1 (latch and dwell), then IDLE with o_busy=0 and address 0.
REQ-039 Asserting i_rst at a mid-SHIFT cycle SHALL immediately set o_oe_n=1, o_sclk=0 and o_busy=0, and release SHALL restart at row 0.
REQ-040 The bench SHALL check o_mem_wr_en=0 throughout, and o_mem_en=1 exactly once per row.
REQ-041 With and without LED_SCAN_BLANK_EN, the bench SHALL check o_oe_n in SHIFT is 1 and 0 respectively.
